systolic_array_ctrl: RTL
========================

# systolic_array_ctrl

Sequencing controller for the N×N output-stationary systolic multiply array. Holds the A and B operand matrices in local buffers, clears the array accumulators, drives the diagonally skewed row/column feed streams, waits for the array to drain, snapshots the N×N results and streams them out over a valid/ready port. It is the only block that drives the array's operand lanes and clear input.

## Interface
- N, 3, array dimension (rows = columns)
- DW, 4, operand width, unsigned
- ACC_W, 10, accumulator width; must be ≥ 2*DW + clog2(N)
- DRAIN_CYC, 1, cycles waited after last feed for array register latency (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  operand buffer write strobe
- wr_sel  in  1  0 = A buffer, 1 = B buffer
- wr_addr  in  clog2(N*N)  row-major element index (i*N+j)
- wr_data  in  DW  element value
- start  in  1  job request; accepted only in IDLE
- busy  out  1  high from start-accept edge until final result handshake
- pe_clr  out  1  synchronous clear to every array accumulator
- a_feed  out  N*DW  lane i (bits i*DW+:DW) feeds array row i
- b_feed  out  N*DW  lane j feeds array column j
- acc_in  in  N*N*ACC_W  array accumulator C[i][j] at slot i*N+j
- res_valid  out  1  result word valid
- res_ready  in  1  consumer accepts result
- res_data  out  ACC_W  result value
- res_idx  out  clog2(N*N)  row-major index of res_data
- res_last  out  1  high with final result (idx N*N-1)
- perf_cycles  out  16  job cycle count (see Configuration)

## Operation
- FSM: IDLE → CLEAR → FEED → DRAIN → CAPTURE → OUTPUT → IDLE.
- IDLE: busy=0; start=1 → CLEAR. wr_en writes buffer selected by wr_sel at wr_addr.
- CLEAR: 1 cycle, pe_clr=1, feeds zero.
- FEED: counter t = 0..3N-3 (3N-2 cycles). a_feed lane i = A[i][t-i] if 0 ≤ t-i < N else 0; b_feed lane j = B[t-j][j] if 0 ≤ t-j < N else 0.
- DRAIN: DRAIN_CYC cycles, feeds zero.
- CAPTURE: 1 cycle; acc_in registered into N*N result buffer.
- OUTPUT: res_idx counts 0..N*N-1; advances only on res_valid & res_ready; handshake at idx N*N-1 → IDLE, busy=0 same edge.
- Writes while busy=1 ignored. start while busy=1 ignored (not queued).
- wr_en and start same IDLE cycle: write lands; job uses updated buffer.
- a_feed, b_feed, pe_clr, res_* are registered outputs.
- Results pass through unmodified; width/overflow is the array's responsibility given ACC_W rule.

## Timing
- Reset: state IDLE; busy, pe_clr, a_feed, b_feed, res_valid, res_data, res_idx, res_last, perf_cycles = 0; both operand buffers and result buffer = 0.
- Reset asserted mid-job: immediate return to IDLE, no result emitted; next job requires new start (array is re-cleared by CLEAR).
- Start accepted at edge of cycle 0: pe_clr in cycle 1; FEED cycles 2..3N-1; first res_valid in cycle 3N+DRAIN_CYC+1 (N=3, D=1: cycle 11).
- Zero backpressure: busy spans 3N+DRAIN_CYC+N*N cycles after accept (N=3, D=1: 19).
- res_valid held with stable res_data/res_idx/res_last while res_ready=0.
- Next start accepted in the cycle after the final handshake.

## Configuration
- SYSTOLIC_CTRL_PERF_EN defined: perf_cycles counts cycles from start accept through final handshake, saturating at 16'hFFFF; cleared on start accept; holds after job.
- Undefined: counter not built, perf_cycles tied 0.

## Structure
- Shared package systolic_pkg: FSM state enum, clog2-derived width constants, DW/ACC_W defaults shared with the array.
- One sub-module: systolic_skew_gen — combinational-plus-register lane mux producing a_feed/b_feed from buffers and t.

## Test plan
- A = identity, B = 1..9 row-major, N=3 → results 1..9 at idx 0..8, res_last at idx 8, first res_valid cycle 11.
- A = B = all 15 → all nine results 675 (no truncation at ACC_W=10).
- res_ready toggled 1-0-0-1 pattern → every idx 0..8 seen exactly once, data stable during stalls, busy=0 after idx 8 handshake.
- start pulsed and wr_en to A[0] during FEED → no second job, A[0] unchanged on next job.
- rst_n low in FEED cycle 4 → all outputs 0 immediately; new job afterwards yields correct products from freshly written buffers.
- With SYSTOLIC_CTRL_PERF_EN, no backpressure, N=3 → perf_cycles = 20; undefined → 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and FSM state type for the systolic array controller.
// Array dimension and widths here must match the multiply array instance.
package systolic_pkg;
   localparam int N         = 3;
   localparam int DW        = 4;
   localparam int ACC_W     = 10;
   localparam int DRAIN_CYC = 1;
   localparam int NN        = N * N;
   localparam int IDX_W     = $clog2(NN);
   localparam int T_W       = $clog2(3 * N);
   localparam int FEED_LAST = 3 * N - 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_CAPTURE,
      S_OUTPUT
   } state_t;
endpackage

// File: rtl/systolic_array_ctrl_if.sv
// Host-side port of the systolic controller: operand writes, job start,
// busy status and the valid/ready result stream.
interface systolic_array_ctrl_if;
   import systolic_pkg::*;

   logic             wr_en;
   logic             wr_sel;
   logic [IDX_W-1:0] wr_addr;
   logic [DW-1:0]    wr_data;
   logic             start;
   logic             busy;
   logic             res_valid;
   logic             res_ready;
   logic [ACC_W-1:0] res_data;
   logic [IDX_W-1:0] res_idx;
   logic             res_last;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start, res_ready,
      input  busy, res_valid, res_data, res_idx, res_last
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start, res_ready,
      output busy, res_valid, res_data, res_idx, res_last
   );
endinterface

// File: rtl/systolic_skew_gen.sv
// Diagonally skewed operand lane mux: lane l carries element t-l of its
// row (A) or column (B) while inside the window, registered onto the feeds.
module systolic_skew_gen
   import systolic_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   feed_en,
   input  logic [T_W-1:0]         t,
   input  logic [NN-1:0][DW-1:0]  a_buf,
   input  logic [NN-1:0][DW-1:0]  b_buf,
   output logic [N*DW-1:0]        a_feed,
   output logic [N*DW-1:0]        b_feed
);
   logic [N*DW-1:0] a_d;
   logic [N*DW-1:0] b_d;

   always_comb begin
      a_d = '0;
      b_d = '0;
      for (int l = 0; l < N; l++) begin
         if (feed_en && int'(t) >= l && int'(t) - l < N) begin
            a_d[l*DW +: DW] = a_buf[IDX_W'(l * N + int'(t) - l)];
            b_d[l*DW +: DW] = b_buf[IDX_W'((int'(t) - l) * N + l)];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_feed <= '0;
         b_feed <= '0;
      end else begin
         a_feed <= a_d;
         b_feed <= b_d;
      end
   end
endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for the NxN output-stationary systolic array.
// Define SYSTOLIC_CTRL_PERF_EN to build the per-job cycle counter.
module systolic_array_ctrl
   import systolic_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   systolic_array_ctrl_if.slave    bus,
   output logic                    pe_clr,
   output logic [N*DW-1:0]         a_feed,
   output logic [N*DW-1:0]         b_feed,
   input  logic [NN*ACC_W-1:0]     acc_in,
   output logic [15:0]             perf_cycles
);
   state_t   state, state_d;
   logic [T_W-1:0] cnt, cnt_d;
   logic     busy_d, clr_d, feed_d, valid_d;
   logic     hs, accept;
   logic [IDX_W-1:0] idx_nx;

   logic [NN-1:0][DW-1:0]    a_buf;
   logic [NN-1:0][DW-1:0]    b_buf;
   logic [NN-1:0][ACC_W-1:0] res_buf;

   assign hs     = bus.res_valid && bus.res_ready;
   assign accept = (state == S_IDLE) && bus.start;
   assign idx_nx = bus.res_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         S_IDLE:    if (bus.start) state_d = S_CLEAR;
         S_CLEAR:   state_d = S_FEED;
         S_FEED:    if (cnt == T_W'(FEED_LAST)) state_d = S_DRAIN;
         S_DRAIN:   if (cnt == T_W'(DRAIN_CYC - 1)) state_d = S_CAPTURE;
         S_CAPTURE: state_d = S_OUTPUT;
         S_OUTPUT:  if (hs && bus.res_last) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registers line up
   // with the state they belong to.
   always_comb begin
      cnt_d = '0;
      if (state_d == state && (state == S_FEED || state == S_DRAIN))
         cnt_d = cnt + 1'b1;
      busy_d  = (state_d != S_IDLE);
      clr_d   = (state_d == S_CLEAR);
      feed_d  = (state_d == S_FEED);
      valid_d = (state_d == S_OUTPUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         bus.busy      <= 1'b0;
         pe_clr        <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_data  <= '0;
         bus.res_idx   <= '0;
         bus.res_last  <= 1'b0;
         a_buf         <= '0;
         b_buf         <= '0;
         res_buf       <= '0;
      end else begin
         cnt           <= cnt_d;
         bus.busy      <= busy_d;
         pe_clr        <= clr_d;
         bus.res_valid <= valid_d;
         if (state == S_IDLE && bus.wr_en && bus.wr_addr < IDX_W'(NN)) begin
            if (bus.wr_sel) b_buf[bus.wr_addr] <= bus.wr_data;
            else            a_buf[bus.wr_addr] <= bus.wr_data;
         end
         if (state == S_CAPTURE) begin
            res_buf      <= acc_in;
            bus.res_data <= acc_in[ACC_W-1:0];
            bus.res_idx  <= '0;
            bus.res_last <= (NN == 1);
         end else if (state == S_OUTPUT && hs && !bus.res_last) begin
            bus.res_idx  <= idx_nx;
            bus.res_data <= res_buf[idx_nx];
            bus.res_last <= (idx_nx == IDX_W'(NN - 1));
         end
      end
   end

   systolic_skew_gen u_skew (
      .clk     (clk),
      .rst_n   (rst_n),
      .feed_en (feed_d),
      .t       (cnt_d),
      .a_buf   (a_buf),
      .b_buf   (b_buf),
      .a_feed  (a_feed),
      .b_feed  (b_feed)
   );

`ifdef SYSTOLIC_CTRL_PERF_EN
   // Accept cycle counts as the first cycle of the job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         perf_cycles <= '0;
      else if (accept)
         perf_cycles <= 16'd1;
      else if (state != S_IDLE && perf_cycles != 16'hFFFF)
         perf_cycles <= perf_cycles + 16'd1;
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
   assign perf_cycles   = '0;
`endif
endmodule
